register_file_v2: RTL

REGISTER_FILE_V2 -- requirements
Module: register_file_v2

---
 rtl/register_file_v2.sv | 113 +++++++++++
 1 files changed

// File: rtl/register_file_v2.sv
// Two-read, one-write register file with registered read ports and a
// sequential clear engine that zeroes the array one entry per cycle.
module register_file_v2 #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]   rd_value,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              clear_request,
  output logic [XLEN-1:0]   rs1_value,
  output logic [XLEN-1:0]   rs2_value,
  output logic              busy,
  output logic              clear_done
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] index, index_next;
  logic              done_next;

  logic [XLEN-1:0]   regs [NUM_REGS];
  logic              wr_commit;
  logic              rd_commit;
  logic [XLEN-1:0]   rd1_next, rd2_next;

  assign busy      = (state == CLEAR);
  assign wr_commit = write_enable && (state == IDLE);
  assign rd_commit = read_enable && (state == IDLE);

  // Clear engine: reset lands in CLEAR so the array is always scrubbed first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR;
      index      <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_next;
      index      <= index_next;
      clear_done <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    index_next = index;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (clear_request) begin
          state_next = CLEAR;
          index_next = '0;
        end
      end
      CLEAR: begin
        if (index == LAST_IDX) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          index_next = index + 1'b1;
        end
      end
      default: begin
        state_next = CLEAR;
        index_next = '0;
      end
    endcase
  end

  // Array storage carries no reset; the clear engine owns it while busy.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      regs[index] <= '0;
    end else if (write_enable && !(ZERO_REG != 0 && rd == '0)) begin
      regs[rd] <= rd_value;
    end
  end

  // Write-first bypass, with the hardwired-zero override applied last.
  always_comb begin
    rd1_next = regs[rs1];
    if (wr_commit && rd == rs1) rd1_next = rd_value;
    if (ZERO_REG != 0 && rs1 == '0) rd1_next = '0;

    rd2_next = regs[rs2];
    if (wr_commit && rd == rs2) rd2_next = rd_value;
    if (ZERO_REG != 0 && rs2 == '0) rd2_next = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rs1_value <= '0;
      rs2_value <= '0;
    end else if (rd_commit) begin
      rs1_value <= rd1_next;
      rs2_value <= rd2_next;
    end
  end

endmodule
